// File: rtl/pll_clk_pkg.sv
// rtl/pll_clk_pkg.sv - shared types and helpers for the post-PLL clock manager
package pll_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } pll_state_t;

    localparam int STABLE_CYCLES_DEF = 1024;
    localparam int LOSS_FILTER_DEF   = 4;
    localparam int STABLE_CNT_W_DEF  = $clog2(STABLE_CYCLES_DEF);
    localparam int FILT_CNT_W_DEF    = $clog2(LOSS_FILTER_DEF);

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A programmed ratio of 0 behaves as divide-by-1
    function automatic int unsigned eff_div(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/pll_clk_manager_ce_divider.sv
// rtl/pll_clk_manager_ce_divider.sv - one clock-enable channel driven by a reloading down-counter
module ce_divider
    import pll_clk_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] reload;

    assign reload = DIV_W'(eff_div(32'(div)) - 32'd1);

    // Held at zero outside RUN so every channel strobes on the first RUN cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= reload;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign ce = run && (cnt_q == '0);

endmodule

// File: rtl/pll_clk_manager.sv
// rtl/pll_clk_manager.sv - lock qualification, system reset sequencing and clock-enable generation
module pll_clk_manager
    import pll_clk_pkg::*;
#(
    parameter int                      NUM_CH        = 3,
    parameter int                      DIV_W         = 16,
    parameter logic [NUM_CH*DIV_W-1:0] CH_DIV        = {16'd1, 16'd4, 16'd45000},
    parameter int                      STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int                      LOSS_FILTER   = LOSS_FILTER_DEF,
    parameter int                      CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_lock,
    output logic              rst_sys_n,
    output logic [NUM_CH-1:0] ce,
    output logic              locked,
    output logic [CNT_W-1:0]  loss_cnt,
    input  logic              loss_clr
);

    localparam int STAB_W = ctr_width(STABLE_CYCLES);
    localparam int FILT_W = ctr_width(LOSS_FILTER);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);

    logic              sync_q1;
    logic              lock_s;
    pll_state_t        state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic              loss_inc;
    logic              run;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync_q1 <= pll_lock;
            lock_s  <= sync_q1;
        end
    end

    // State and window counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
            filt_q  <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            filt_q  <= filt_d;
        end
    end

    // Next state: stability window before RUN, glitch filter while in RUN
    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        filt_d   = filt_q;
        loss_inc = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                stab_d = '0;
                filt_d = '0;
                if (lock_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RUN;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RUN: begin
                if (lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_LAST) begin
                    state_d  = LOST;
                    filt_d   = '0;
                    loss_inc = 1'b1;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            LOST: begin
                state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign run       = (state_q == RUN);
    assign rst_sys_n = run;
    assign locked    = run;

    // Saturating loss counter; clear wins over a simultaneous increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (loss_clr) begin
            loss_cnt <= '0;
        end else if (loss_inc && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_divider #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk     (clk),
            .reset_n (reset_n),
            .run     (run),
            .div     (CH_DIV[i*DIV_W +: DIV_W]),
            .ce      (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_clk_manager.sv
// tb/tb_pll_clk_manager.sv - directed self-checking bench for pll_clk_manager
module tb_pll_clk_manager;

    logic       clk;
    logic       reset_n;
    logic       pll_lock;
    logic       loss_clr;
    logic       rst_a, rst_b;
    logic       locked_a, locked_b;
    logic [2:0] ce_a, ce_b;
    logic [7:0] loss_a;
    logic [1:0] loss_b;

    int n_cmp = 0;
    int n_bad = 0;
    int k;

    typedef struct packed {
        logic       lock;
        logic       rst;
        logic [2:0] ce_a;
        logic [2:0] ce_b;
    } vec_t;

    vec_t tbl [12];

    pll_clk_manager #(
        .NUM_CH(3), .DIV_W(16), .CH_DIV({16'd1, 16'd4, 16'd45000}),
        .STABLE_CYCLES(16), .LOSS_FILTER(4), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .rst_sys_n(rst_a),
        .ce(ce_a), .locked(locked_a), .loss_cnt(loss_a), .loss_clr(loss_clr)
    );

    pll_clk_manager #(
        .NUM_CH(3), .DIV_W(16), .CH_DIV({16'd0, 16'd1, 16'd3}),
        .STABLE_CYCLES(16), .LOSS_FILTER(4), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .rst_sys_n(rst_b),
        .ce(ce_b), .locked(locked_b), .loss_cnt(loss_b), .loss_clr(loss_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges from the current cycle until rst_sys_n of dut_a reads 1; 61 means timeout
    task automatic wait_release(output int cyc);
        int i;
        i = 0;
        cyc = 61;
        while (i < 60 && cyc == 61) begin
            @(posedge clk); #1;
            i++;
            if (rst_a) cyc = i;
        end
    endtask

    // Called one step after an edge while in RUN: forces a filtered loss, then relocks
    task automatic do_loss(input logic clr);
        int c;
        pll_lock = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("filter_hold", {rst_a, rst_b}, 2'b11);
        loss_clr = clr;
        @(posedge clk); #1;
        loss_clr = 1'b0;
        check("lost_outputs", {rst_a, rst_b, locked_a, locked_b, ce_a, ce_b}, 10'd0);
        pll_lock = 1'b1;
        wait_release(c);
        check("relock_cycle", c, 19);
        check("relock_ce", {ce_a, ce_b}, 6'b111111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 3'b100, 3'b110};
        tbl[1]  = '{1'b1, 1'b1, 3'b100, 3'b110};
        tbl[2]  = '{1'b0, 1'b1, 3'b100, 3'b111};
        tbl[3]  = '{1'b0, 1'b1, 3'b110, 3'b110};
        tbl[4]  = '{1'b0, 1'b1, 3'b100, 3'b110};
        tbl[5]  = '{1'b1, 1'b1, 3'b100, 3'b111};
        tbl[6]  = '{1'b1, 1'b1, 3'b100, 3'b110};
        tbl[7]  = '{1'b1, 1'b1, 3'b110, 3'b110};
        tbl[8]  = '{1'b1, 1'b1, 3'b100, 3'b111};
        tbl[9]  = '{1'b1, 1'b1, 3'b100, 3'b110};
        tbl[10] = '{1'b1, 1'b1, 3'b100, 3'b110};
        tbl[11] = '{1'b1, 1'b1, 3'b110, 3'b111};

        reset_n  = 1'b0;
        pll_lock = 1'b0;
        loss_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {rst_a, locked_a, ce_a, loss_a, rst_b, locked_b, ce_b, loss_b}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("wait_lock_idle", {rst_a, rst_b, ce_a, ce_b}, 8'd0);
        end

        // Stable lock from cycle 0 releases at cycle 19 with all strobes aligned
        pll_lock = 1'b1;
        wait_release(k);
        check("release_cycle", k, 19);
        check("release_flags", {rst_a, rst_b, locked_a, locked_b}, 4'hf);
        check("first_ce_a", ce_a, 3'b111);
        check("first_ce_b", ce_b, 3'b111);

        // Cadence in RUN with a 3-cycle lock glitch that must be filtered
        for (int i = 0; i < 12; i++) begin
            pll_lock = tbl[i].lock;
            @(posedge clk); #1;
            check($sformatf("run_vec%0d", i), {rst_a, ce_a, ce_b}, {tbl[i].rst, tbl[i].ce_a, tbl[i].ce_b});
        end
        check("glitch_no_loss", {loss_a, loss_b}, 10'd0);

        do_loss(1'b0);
        check("loss_one", {loss_a, loss_b}, {8'd1, 2'd1});
        for (int i = 0; i < 4; i++) do_loss(1'b0);
        check("loss_a_five", loss_a, 8'd5);
        check("loss_b_sat", loss_b, 2'd3);

        do_loss(1'b1);
        check("clr_wins", {loss_a, loss_b}, 10'd0);
        do_loss(1'b0);
        check("loss_after_clr", {loss_a, loss_b}, {8'd1, 2'd1});

        // Asynchronous reset between edges while running
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", {rst_a, locked_a, ce_a, loss_a, rst_b, locked_b, ce_b, loss_b}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_release(k);
        check("post_reset_release", k, 19);

        // Lock chatter during the stability window restarts it
        @(posedge clk); #1;
        pll_lock = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        pll_lock = 1'b1;
        k = 61;
        for (int i = 1; i <= 60 && k == 61; i++) begin
            @(posedge clk); #1;
            pll_lock = (i != 10);
            if (rst_a) k = i;
        end
        check("chatter_release", k, 30);
        check("chatter_no_loss", {loss_a, loss_b}, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
